// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the two-master SRAM bus arbiter.
// Contents: default bus widths (matching the WB address/data buses),
// timeout counter width and the arbiter state encoding.
package ram_bus_arbiter_pkg;

   localparam int unsigned WB_ADDR_W = 32;
   localparam int unsigned WB_DATA_W = 32;

   // Timeout counter width; TIMEOUT is limited to 1..65535.
   localparam int unsigned CNT_W     = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2,
      ARB_GAP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-request picker: fixed priority (req[0] wins ties) or round-robin
// (the requester that did not win last time wins ties).
// Ports:
//   req   - request vector, bit x = master x
//   last  - index of the master that won the previous transaction
//   fixed - 1 selects fixed priority, 0 selects round-robin
//   win   - one-hot winner, 00 when nobody requests
module arb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       fixed,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = (fixed || last) ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one SRAM bus port between the data-memory master (m0) and the
// instruction-fetch master (m1). The grant is held for one whole
// transaction, one idle GAP cycle separates transactions, and a grant
// that sees no ack for TIMEOUT cycles is aborted with an error pulse.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   m0_*/m1_* inputs  - master address, write data, request, write enable
//   m0_*/m1_* outputs - read data, ack, timeout error (combinational)
//   bus_*             - slave port; driven from the granted master
//   grant_o           - one-hot current grant
module ram_bus_arbiter
   import ram_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = WB_ADDR_W,
   parameter int unsigned DATA_W     = WB_DATA_W,
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   input  logic              m0_select_i,
   input  logic              m0_we_i,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,

   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   input  logic              m1_select_i,
   input  logic              m1_we_i,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,

   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_data_o,
   input  logic [DATA_W-1:0] bus_data_i,
   output logic              bus_select_o,
   output logic              bus_we_o,
   input  logic              bus_ack_i,

   output logic [1:0]        grant_o
);

   arb_state_t       state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       win;
   logic             g1;
   logic             cur_sel;
   logic             tmo_hit;

   arb_rr2 u_pick (
      .req   ({m1_select_i, m0_select_i}),
      .last  (last_q),
      .fixed (FIXED_PRIO != 0),
      .win   (win)
   );

   assign g1      = (state_q == ARB_GNT1);
   assign cur_sel = g1 ? m1_select_i : m0_select_i;
   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State, last-winner and timeout counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and bus / master muxing
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      bus_addr_o   = '0;
      bus_data_o   = '0;
      bus_select_o = 1'b0;
      bus_we_o     = 1'b0;
      m0_data_o    = '0;
      m0_ack_o     = 1'b0;
      m0_err_o     = 1'b0;
      m1_data_o    = '0;
      m1_ack_o     = 1'b0;
      m1_err_o     = 1'b0;
      grant_o      = 2'b00;

      case (state_q)
         ARB_IDLE: begin
            // Counter is held clear here so every grant starts from zero.
            cnt_d = '0;
            if (win[0]) begin
               state_d = ARB_GNT0;
            end else if (win[1]) begin
               state_d = ARB_GNT1;
            end
         end

         ARB_GNT0, ARB_GNT1: begin
            grant_o      = g1 ? 2'b10 : 2'b01;
            bus_select_o = cur_sel;
            bus_we_o     = g1 ? m1_we_i   : m0_we_i;
            bus_addr_o   = g1 ? m1_addr_i : m0_addr_i;
            bus_data_o   = g1 ? m1_data_i : m0_data_i;

            // Ack beats timeout when both land in the same cycle.
            if (bus_ack_i) begin
               if (g1) begin
                  m1_ack_o  = 1'b1;
                  m1_data_o = bus_data_i;
               end else begin
                  m0_ack_o  = 1'b1;
                  m0_data_o = bus_data_i;
               end
               state_d = ARB_GAP;
               last_d  = g1;
            end else if (!cur_sel) begin
               state_d = ARB_GAP;
               last_d  = g1;
            end else if (tmo_hit) begin
               if (g1) begin
                  m1_err_o = 1'b1;
               end else begin
                  m0_err_o = 1'b1;
               end
               state_d = ARB_GAP;
               last_d  = g1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ARB_GAP: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter. Instance A: round-robin, TIMEOUT=4.
// Instance B: fixed priority, TIMEOUT=255. Both share the master inputs.
module tb_ram_bus_arbiter;

   localparam logic [31:0] M0_ADDR = 32'h0000_0100;
   localparam logic [31:0] M1_ADDR = 32'h0000_0040;
   localparam logic [31:0] M0_WD   = 32'h1111_0000;
   localparam logic [31:0] M1_WD   = 32'h2222_0000;
   localparam logic [31:0] SL_RD   = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, bus_rd;
   logic        m0_sel, m0_we, m1_sel, m1_we;
   logic        vec_ack_a, auto_a, auto_b;
   logic        ack_a, ack_b;

   logic [31:0] a_m0_rd, a_m1_rd, a_baddr, a_bwd;
   logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_bsel, a_bwe;
   logic [1:0]  a_grant;
   logic [31:0] b_m0_rd, b_m1_rd, b_baddr, b_bwd;
   logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_bsel, b_bwe;
   logic [1:0]  b_grant;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Slave models: vector-driven ack, or immediate ack on select
   assign ack_a = vec_ack_a | (auto_a & a_bsel);
   assign ack_b = auto_b & b_bsel;

   ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr), .m0_data_i(m0_wd), .m0_select_i(m0_sel), .m0_we_i(m0_we),
      .m0_data_o(a_m0_rd), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
      .m1_addr_i(m1_addr), .m1_data_i(m1_wd), .m1_select_i(m1_sel), .m1_we_i(m1_we),
      .m1_data_o(a_m1_rd), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
      .bus_addr_o(a_baddr), .bus_data_o(a_bwd), .bus_data_i(bus_rd),
      .bus_select_o(a_bsel), .bus_we_o(a_bwe), .bus_ack_i(ack_a),
      .grant_o(a_grant)
   );

   ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT(255)) dut_b (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr), .m0_data_i(m0_wd), .m0_select_i(m0_sel), .m0_we_i(m0_we),
      .m0_data_o(b_m0_rd), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
      .m1_addr_i(m1_addr), .m1_data_i(m1_wd), .m1_select_i(m1_sel), .m1_we_i(m1_we),
      .m1_data_o(b_m1_rd), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
      .bus_addr_o(b_baddr), .bus_data_o(b_bwd), .bus_data_i(bus_rd),
      .bus_select_o(b_bsel), .bus_we_o(b_bwe), .bus_ack_i(ack_b),
      .grant_o(b_grant)
   );

   typedef struct {
      logic       rst, s0, s1, ack;
      logic [1:0] gnt;
      logic       bsel;
      logic       a0, a1, e0, e1;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];
   int   exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic setv(input int i, input logic r, input logic s0, input logic s1,
                       input logic ack, input logic [1:0] g, input logic bs,
                       input logic a0, input logic a1, input logic e0, input logic e1);
      vecs[i] = '{rst: r, s0: s0, s1: s1, ack: ack, gnt: g, bsel: bs,
                  a0: a0, a1: a1, e0: e0, e1: e1};
   endtask

   task automatic reset_all();
      @(posedge clk);
      #1;
      rst = 1'b1; m0_sel = 1'b0; m1_sel = 1'b0;
      vec_ack_a = 1'b0; auto_a = 1'b0; auto_b = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Holds both requests with an immediately-acking slave and checks the
   // grant order against the scoreboard, the GAP cycle and ack spacing.
   task automatic sb_run(input string tag, input bit use_b);
      int  cyc = 0;
      int  last_ack = -1;
      bit  gap_pend = 1'b0;
      bit  saw11 = 1'b0;
      bit  saw_m1 = 1'b0;
      logic       ack0, ack1, sel;
      logic [1:0] g;
      int  got, expv;
      while (cyc < 80 && (exp_q.size() != 0 || gap_pend)) begin
         @(negedge clk);
         cyc++;
         ack0 = use_b ? b_m0_ack : a_m0_ack;
         ack1 = use_b ? b_m1_ack : a_m1_ack;
         sel  = use_b ? b_bsel   : a_bsel;
         g    = use_b ? b_grant  : a_grant;
         if (g == 2'b11) saw11 = 1'b1;
         if (ack1) saw_m1 = 1'b1;
         if (ack0 || ack1) begin
            got  = ack1 ? 1 : 0;
            expv = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
            chk({tag, " order"}, 64'(got), 64'(expv));
            if (last_ack >= 0) chk({tag, " ack spacing"}, 64'(cyc - last_ack), 64'(3));
            last_ack = cyc;
            gap_pend = 1'b1;
         end else if (gap_pend) begin
            chk({tag, " gap select"}, 64'(sel), 64'(0));
            chk({tag, " gap grant"}, 64'(g), 64'(0));
            gap_pend = 1'b0;
         end
      end
      chk({tag, " pending acks"}, 64'(exp_q.size()), 64'(0));
      chk({tag, " grant 11 seen"}, 64'(saw11), 64'(0));
      if (use_b) chk({tag, " m1 acked"}, 64'(saw_m1), 64'(0));
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      m0_addr = M0_ADDR; m0_wd = M0_WD; m0_we = 1'b1; m0_sel = 1'b0;
      m1_addr = M1_ADDR; m1_wd = M1_WD; m1_we = 1'b0; m1_sel = 1'b0;
      bus_rd = SL_RD; vec_ack_a = 1'b0; auto_a = 1'b0; auto_b = 1'b0;

      //     i  rst s0 s1 ack gnt   bsel a0 a1 e0 e1
      // m1 read, ack on 4th grant cycle (coincides with TIMEOUT-1: ack wins)
      setv( 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      setv( 1, 0, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0);
      setv( 2, 0, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0);
      setv( 3, 0, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0);
      setv( 4, 0, 0, 1, 1, 2'b10, 1, 0, 1, 0, 0);
      setv( 5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv( 6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      // m0 write, slave silent: err on 4th GNT0 cycle
      setv( 7, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv( 8, 0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
      setv( 9, 0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
      setv(10, 0, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
      setv(11, 0, 1, 0, 0, 2'b01, 1, 0, 0, 1, 0);
      setv(12, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(13, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      // both request, m1 wins (m0 won last); m1 drops select, m0 served next
      setv(14, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(15, 0, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0);
      setv(16, 0, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0);
      setv(17, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
      setv(18, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(19, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(20, 0, 1, 0, 1, 2'b01, 1, 1, 0, 0, 0);
      setv(21, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      // reset mid GNT0, then m0 wins first tie after reset
      setv(22, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(23, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0);
      setv(24, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(25, 0, 1, 1, 1, 2'b01, 1, 1, 0, 0, 0);
      setv(26, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(27, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
      setv(28, 0, 0, 1, 1, 2'b10, 1, 0, 1, 0, 0);

      @(posedge clk);
      @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         logic [31:0] e_addr, e_wd;
         @(posedge clk);
         #1;
         rst = vecs[i].rst; m0_sel = vecs[i].s0; m1_sel = vecs[i].s1;
         vec_ack_a = vecs[i].ack;
         @(negedge clk);
         e_addr = vecs[i].gnt[0] ? M0_ADDR : (vecs[i].gnt[1] ? M1_ADDR : 32'h0);
         e_wd   = vecs[i].gnt[0] ? M0_WD   : (vecs[i].gnt[1] ? M1_WD   : 32'h0);
         chk($sformatf("v%0d grant", i), 64'(a_grant), 64'(vecs[i].gnt));
         chk($sformatf("v%0d bus_select", i), 64'(a_bsel), 64'(vecs[i].bsel));
         chk($sformatf("v%0d bus_addr", i), 64'(a_baddr), 64'(e_addr));
         chk($sformatf("v%0d bus_data", i), 64'(a_bwd), 64'(e_wd));
         chk($sformatf("v%0d bus_we", i), 64'(a_bwe), 64'(vecs[i].gnt[0]));
         chk($sformatf("v%0d ack_err", i), 64'({a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}),
             64'({vecs[i].a0, vecs[i].a1, vecs[i].e0, vecs[i].e1}));
         chk($sformatf("v%0d m0_data", i), 64'(a_m0_rd), 64'(vecs[i].a0 ? SL_RD : 32'h0));
         chk($sformatf("v%0d m1_data", i), 64'(a_m1_rd), 64'(vecs[i].a1 ? SL_RD : 32'h0));
      end

      // Round-robin: strict alternation starting with m0 after reset
      reset_all();
      chk("rr reset grant", 64'(a_grant), 64'(0));
      auto_a = 1'b1;
      m0_sel = 1'b1; m1_sel = 1'b1;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
      sb_run("rr", 1'b0);

      // Fixed priority: m0 takes every transaction, m1 starves
      reset_all();
      chk("fp reset select", 64'(b_bsel), 64'(0));
      auto_b = 1'b1;
      m0_sel = 1'b1; m1_sel = 1'b1;
      for (int k = 0; k < 4; k++) exp_q.push_back(0);
      sb_run("fp", 1'b1);

      reset_all();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
